ipdb_common_rst_gen: RTL
========================

IPDB_COMMON_RST_GEN -- requirements
Module: ipdb_common_rst_gen

Interface
REQ-001 Parameter STRETCH_W, default 8: width of the reset stretch count.
REQ-002 Parameter TO_CYCLES, default 1024: acknowledge timeout in clk_i cycles, used only with IPDB_RST_GEN_TIMEOUT_EN.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 scan_mode_i  input  1  scan mode; forces rst_req_n_o = reset_n_i.
REQ-006 req_i  input  1  reset request; sampled only in IDLE.
REQ-007 stretch_i  input  STRETCH_W  minimum low time of rst_req_n_o in cycles, captured on request acceptance.
REQ-008 rst_ack_i  input  1  asynchronous status from destination; 1 = destination held in reset.
REQ-009 rst_req_n_o  output  1  active-low reset request to destination domain.
REQ-010 busy_o  output  1  high in every state except IDLE.
REQ-011 done_o  output  1  one-cycle pulse on sequence completion.
REQ-012 timeout_o  output  1  sticky acknowledge-timeout flag.

Function
REQ-013 rst_ack_i SHALL be synchronized by a 2-flop synchronizer (reset value 0) before use; ack_s denotes its output (2-cycle latency).
REQ-014 FSM states SHALL be IDLE, ASSERT, WAIT_ACK, RELEASE, DONE.
REQ-015 IDLE: req_i=1 at an edge -> ASSERT; stretch counter loaded with stretch_i, or 1 if stretch_i=0; timeout_o cleared.
REQ-016 rst_req_n_o SHALL be registered, low in ASSERT and WAIT_ACK, high in all other states (first low cycle is the one after acceptance).
REQ-017 ASSERT: counter decrements each cycle; when counter=1 -> WAIT_ACK, giving exactly max(stretch_i,1) low cycles in ASSERT.
REQ-018 WAIT_ACK: ack_s=1 -> RELEASE; rst_req_n_o remains low until then.
REQ-019 RELEASE: ack_s=0 -> DONE.
REQ-020 DONE: done_o=1 for one cycle, then unconditionally -> IDLE.
REQ-021 req_i SHALL be ignored in every state except IDLE, including the DONE cycle; no request is queued.
REQ-022 stretch_i changes after acceptance SHALL have no effect on the running sequence.
REQ-023 Counter SHALL NOT wrap; stretch_i = 2^STRETCH_W-1 yields that many low cycles.
REQ-024 If ack_s is already 1 on entry to WAIT_ACK, the transition to RELEASE SHALL occur on the next edge.
REQ-025 scan_mode_i=1 SHALL make rst_req_n_o combinationally equal reset_n_i; the FSM continues unaffected.

Reset
REQ-026 reset_n_i low SHALL asynchronously force: state IDLE, counters 0, synchronizer 0, rst_req_n_o=1, busy_o=0, done_o=0, timeout_o=0.
REQ-027 Reset mid-sequence SHALL abort immediately, with no done_o pulse; the next sequence needs a fresh req_i.

Configuration
REQ-028 With IPDB_RST_GEN_TIMEOUT_EN defined: a timeout counter SHALL clear on entry to WAIT_ACK and to RELEASE and count each cycle there. Reaching TO_CYCLES SHALL set timeout_o and go to DONE, with rst_req_n_o high and done_o pulsing.
REQ-029 Without IPDB_RST_GEN_TIMEOUT_EN: no timeout counter; WAIT_ACK and RELEASE wait indefinitely; timeout_o SHALL be tied 0.

Structure
REQ-030 State enum type and default constants (STRETCH_W, TO_CYCLES) SHALL reside in the shared package ipdb_common_pkg.
REQ-031 The ack synchronizer SHALL be an instance of the existing ipdb_common_sync sub-module (clk_i, reset_n_i, data_i=rst_ack_i); no other sub-modules.

Verification
REQ-032 stretch_i=4, req_i pulse at cycle 0, ack rises at cycle 6 and falls at cycle 12 -> rst_req_n_o low cycles 1..8, ack_s high at 8, RELEASE 9..14, done_o at 15, busy_o 1..15.
REQ-033 stretch_i=0 and rst_ack_i tied 1 -> exactly 1 ASSERT cycle, then WAIT_ACK 1 cycle; done_o follows rst_ack_i falling edge by 3 cycles.
REQ-034 req_i held high through whole sequence -> a second sequence starts only on the cycle after DONE (back-to-back, no request lost or duplicated).
REQ-035 reset_n_i pulsed low while in WAIT_ACK -> rst_req_n_o=1 and busy_o=0 immediately, no done_o.
REQ-036 With macro, TO_CYCLES=16, rst_ack_i tied 0 -> timeout_o=1 and done_o pulse 16 cycles after WAIT_ACK entry; next request clears timeout_o.
REQ-037 scan_mode_i=1, toggle reset_n_i -> rst_req_n_o follows reset_n_i in the same cycle regardless of FSM state.

Source files
------------

// File: rtl/ipdb_common_pkg.sv
// ipdb_common_pkg: shared types and default constants for the ipdb_common blocks.
//   rst_gen_state_e      reset-generator sequencing states
//   RST_GEN_STRETCH_W    default width of the reset stretch count
//   RST_GEN_TO_CYCLES    default acknowledge timeout in clock cycles
package ipdb_common_pkg;

    localparam int unsigned RST_GEN_STRETCH_W = 8;
    localparam int unsigned RST_GEN_TO_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_DONE     = 3'd4
    } rst_gen_state_e;

endpackage

// File: rtl/ipdb_common_sync.sv
// ipdb_common_sync: two-flop synchronizer for a single asynchronous bit.
//   clk_i      destination clock
//   reset_n_i  asynchronous active-low reset (flops clear to 0)
//   data_i     asynchronous input
//   data_o     synchronized output, two cycles of latency
module ipdb_common_sync (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic data_i,
    output logic data_o
);

    logic [1:0] r_sync;

    // Shift chain; only r_sync[1] is considered metastability-safe.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], data_i};
        end
    end

    assign data_o = r_sync[1];

endmodule

// File: rtl/ipdb_common_rst_gen.sv
// ipdb_common_rst_gen: sequences a reset request into another domain.
// On req_i in IDLE it drives rst_req_n_o low for at least max(stretch_i,1)
// cycles, waits for the destination to acknowledge reset, waits for the
// acknowledge to drop again, then pulses done_o.
// Optional macro IPDB_RST_GEN_TIMEOUT_EN adds an acknowledge timeout that
// aborts WAIT_ACK/RELEASE after TO_CYCLES cycles and sets sticky timeout_o.
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   scan_mode_i  scan mode: rst_req_n_o follows reset_n_i directly
//   req_i        reset request, sampled only in IDLE
//   stretch_i    minimum low time of rst_req_n_o, captured on acceptance
//   rst_ack_i    asynchronous "destination in reset" status
//   rst_req_n_o  active-low reset request to destination
//   busy_o       high whenever the sequencer is not IDLE
//   done_o       one-cycle completion pulse
//   timeout_o    sticky acknowledge-timeout flag (0 without the macro)
module ipdb_common_rst_gen
    import ipdb_common_pkg::*;
#(
    parameter int unsigned STRETCH_W = RST_GEN_STRETCH_W,
    parameter int unsigned TO_CYCLES = RST_GEN_TO_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 scan_mode_i,
    input  logic                 req_i,
    input  logic [STRETCH_W-1:0] stretch_i,
    input  logic                 rst_ack_i,
    output logic                 rst_req_n_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o
);

    logic                 w_ack_s;
    rst_gen_state_e       r_state;
    rst_gen_state_e       w_state_nxt;
    logic [STRETCH_W-1:0] r_cnt;
    logic [STRETCH_W-1:0] w_cnt_nxt;
    logic                 r_rst_req_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_rst_req_n_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

`ifdef IPDB_RST_GEN_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;
`endif

    ipdb_common_sync u_ack_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (rst_ack_i),
        .data_o    (w_ack_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counters and next-cycle outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rst_req_n_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
`ifdef IPDB_RST_GEN_TIMEOUT_EN
        w_to_cnt_nxt    = r_to_cnt;
        w_timeout_nxt   = r_timeout;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_state_nxt = ST_ASSERT;
                    // A zero stretch still yields one low cycle.
                    w_cnt_nxt   = (stretch_i == '0) ? STRETCH_W'(1) : stretch_i;
`ifdef IPDB_RST_GEN_TIMEOUT_EN
                    w_timeout_nxt = 1'b0;
`endif
                end
            end
            ST_ASSERT: begin
                w_cnt_nxt = r_cnt - STRETCH_W'(1);
                if (r_cnt == STRETCH_W'(1)) begin
                    w_state_nxt = ST_WAIT_ACK;
`ifdef IPDB_RST_GEN_TIMEOUT_EN
                    w_to_cnt_nxt = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                if (w_ack_s) begin
                    w_state_nxt = ST_RELEASE;
`ifdef IPDB_RST_GEN_TIMEOUT_EN
                    w_to_cnt_nxt = '0;
                end else if (r_to_cnt == TO_W'(TO_CYCLES - 1)) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
`endif
                end
            end
            ST_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = ST_DONE;
`ifdef IPDB_RST_GEN_TIMEOUT_EN
                end else if (r_to_cnt == TO_W'(TO_CYCLES - 1)) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        w_rst_req_n_nxt = !((w_state_nxt == ST_ASSERT) || (w_state_nxt == ST_WAIT_ACK));
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_nxt      = (w_state_nxt == ST_DONE);
    end

    // Stretch counter and registered outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt       <= '0;
            r_rst_req_n <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_rst_req_n <= w_rst_req_n_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

`ifdef IPDB_RST_GEN_TIMEOUT_EN
    // Acknowledge timeout counter and sticky flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    // Scan bypass: destination reset follows the chip reset directly.
    assign rst_req_n_o = scan_mode_i ? reset_n_i : r_rst_req_n;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
